// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit seven-segment scan driver.
// Segment and select levels are active-low throughout.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } phase_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] SEL_OFF = 4'hF;

    // Active-high gfedcba patterns, indexed by hex nibble
    localparam logic [6:0] HEX_PAT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble plus decimal point to active-low segment byte
// in {dp,g,f,e,d,c,b,a} order.
module seg7_hex_decode (
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    import seg7_pkg::*;

    always_comb begin
        seg = ~{dp, HEX_PAT[nibble]};
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Round-robin 4-digit scan driver with per-slot blanking and a
// frame-coherent shadow/active register pair for display content.
module seg7_scan_driver #(
    parameter int unsigned DWELL_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_value,
    input  logic [3:0]  wr_dp,
    input  logic [3:0]  wr_en,
    output logic [7:0]  io_seg,
    output logic [3:0]  io_sel,
    output logic        frame_start
);

    import seg7_pkg::*;

    localparam int unsigned CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t LAST_CNT   = cnt_t'(DWELL_CYCLES - 1);
    localparam cnt_t BLANK_LAST = cnt_t'(BLANK_CYCLES - 1);

    logic [15:0] shadow_value;
    logic [3:0]  shadow_dp;
    logic [3:0]  shadow_en;
    logic [15:0] active_value;
    logic [3:0]  active_dp;
    logic [3:0]  active_en;
    logic        pending;

    phase_t      phase;
    logic [1:0]  idx;
    cnt_t        cnt;

    phase_t      nxt_phase;
    logic [1:0]  nxt_idx;
    cnt_t        nxt_cnt;
    logic        slot_end;
    logic        boundary;
    logic        fire;
    logic        lit_next;
    logic [3:0]  nxt_nibble;
    logic        nxt_dp;
    logic [3:0]  sel_onehot;
    logic [7:0]  dec_seg;

    assign wr_ready = ~pending;

    // cnt is the position within the current slot; phase follows from it
    always_comb begin
        slot_end  = (cnt == LAST_CNT);
        boundary  = slot_end && (idx == 2'd3);
        fire      = wr_valid && !pending;
        nxt_cnt   = cnt;
        nxt_idx   = idx;
        nxt_phase = phase;
        if (slot_end) begin
            nxt_cnt   = '0;
            nxt_idx   = idx + 2'd1;
            nxt_phase = BLANK;
        end else begin
            nxt_cnt = cnt + cnt_t'(1);
            if (cnt == BLANK_LAST) begin
                nxt_phase = ON;
            end
        end
    end

    // Outputs are computed for the upcoming state so they stay aligned
    // with the registered phase; active only changes on entry to BLANK.
    always_comb begin
        nxt_nibble = active_value[{nxt_idx, 2'b00} +: 4];
        nxt_dp     = active_dp[nxt_idx];
        lit_next   = (nxt_phase == ON) && active_en[nxt_idx];
        sel_onehot = 4'b0001 << nxt_idx;
    end

    seg7_hex_decode u_decode (
        .nibble (nxt_nibble),
        .dp     (nxt_dp),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_en    <= '0;
            active_value <= '0;
            active_dp    <= '0;
            active_en    <= '0;
            pending      <= 1'b0;
            phase        <= BLANK;
            idx          <= '0;
            cnt          <= '0;
            io_seg       <= SEG_OFF;
            io_sel       <= SEL_OFF;
            frame_start  <= 1'b0;
        end else begin
            phase       <= nxt_phase;
            idx         <= nxt_idx;
            cnt         <= nxt_cnt;
            frame_start <= boundary;
            io_sel      <= lit_next ? ~sel_onehot : SEL_OFF;
            io_seg      <= lit_next ? dec_seg : SEG_OFF;

            if (fire) begin
                shadow_value <= wr_value;
                shadow_dp    <= wr_dp;
                shadow_en    <= wr_en;
                pending      <= 1'b1;
            end else if (boundary && pending) begin
                active_value <= shadow_value;
                active_dp    <= shadow_dp;
                active_en    <= shadow_en;
                pending      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DWELL=10, BLANK=2; cycle numbers
// count clock edges since the most recent reset release.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_value;
    logic [3:0]  wr_dp;
    logic [3:0]  wr_en;
    logic [7:0]  io_seg;
    logic [3:0]  io_sel;
    logic        frame_start;

    int unsigned checks;
    int unsigned errors;
    int unsigned cyc;

    typedef struct {
        int unsigned cyc;
        logic        wr;
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [3:0]  sel;
        logic [7:0]  seg;
        logic        fs;
        logic        rdy;
    } vec_t;

    vec_t t1[$];
    vec_t t2[$];

    seg7_scan_driver #(
        .DWELL_CYCLES (10),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_value    (wr_value),
        .wr_dp       (wr_dp),
        .wr_en       (wr_en),
        .io_seg      (io_seg),
        .io_sel      (io_sel),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int unsigned c, input logic w, input logic [15:0] v,
                                input logic [3:0] d, input logic [3:0] e, input logic [3:0] s,
                                input logic [7:0] g, input logic f, input logic r);
        vec_t x;
        x.cyc = c; x.wr = w; x.val = v; x.dp = d; x.en = e;
        x.sel = s; x.seg = g; x.fs = f; x.rdy = r;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        wr_valid = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] s, input logic [7:0] g,
                              input logic f, input logic r);
        chk($sformatf("%s c%0d io_sel", tag, cyc), 32'(io_sel), 32'(s));
        chk($sformatf("%s c%0d io_seg", tag, cyc), 32'(io_seg), 32'(g));
        chk($sformatf("%s c%0d frame_start", tag, cyc), 32'(frame_start), 32'(f));
        chk($sformatf("%s c%0d wr_ready", tag, cyc), 32'(wr_ready), 32'(r));
    endtask

    task automatic run_table(input vec_t tbl[$], input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            while (cyc < tbl[i].cyc) step();
            check_outs(tag, tbl[i].sel, tbl[i].seg, tbl[i].fs, tbl[i].rdy);
            if (tbl[i].wr) begin
                wr_valid = 1'b1;
                wr_value = tbl[i].val;
                wr_dp    = tbl[i].dp;
                wr_en    = tbl[i].en;
            end
        end
    endtask

    task automatic drive_write(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        wr_valid = 1'b1;
        wr_value = v;
        wr_dp    = d;
        wr_en    = e;
    endtask

    initial begin
        logic [3:0] one;
        logic [3:0] exp_sel;
        logic [7:0] exp_seg;
        logic [7:0] digit_seg [4];
        int unsigned k;
        int unsigned s;

        checks   = 0;
        errors   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_value = '0;
        wr_dp    = '0;
        wr_en    = '0;

        // Content, handshake, boundary write, then mid-frame reset
        t1.push_back(mk(0,   0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0, 1));
        t1.push_back(mk(1,   1, 16'h1234, 4'b0001, 4'hF, 4'hF, 8'hFF, 0, 1));
        t1.push_back(mk(2,   0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0, 0));
        t1.push_back(mk(5,   0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0, 0));
        t1.push_back(mk(39,  0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0, 0));
        t1.push_back(mk(40,  0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 1, 1));
        t1.push_back(mk(41,  0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0, 1));
        t1.push_back(mk(42,  0, 16'h0, 4'h0, 4'h0, 4'hE, 8'h19, 0, 1));
        t1.push_back(mk(49,  0, 16'h0, 4'h0, 4'h0, 4'hE, 8'h19, 0, 1));
        t1.push_back(mk(50,  0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0, 1));
        t1.push_back(mk(52,  0, 16'h0, 4'h0, 4'h0, 4'hD, 8'hB0, 0, 1));
        t1.push_back(mk(62,  0, 16'h0, 4'h0, 4'h0, 4'hB, 8'hA4, 0, 1));
        t1.push_back(mk(72,  0, 16'h0, 4'h0, 4'h0, 4'h7, 8'hF9, 0, 1));
        t1.push_back(mk(79,  0, 16'h0, 4'h0, 4'h0, 4'h7, 8'hF9, 0, 1));
        t1.push_back(mk(80,  0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 1, 1));
        t1.push_back(mk(81,  1, 16'hABCD, 4'b0000, 4'hF, 4'hF, 8'hFF, 0, 1));
        t1.push_back(mk(82,  0, 16'h0, 4'h0, 4'h0, 4'hE, 8'h19, 0, 0));
        t1.push_back(mk(85,  1, 16'h5555, 4'b1111, 4'hF, 4'hE, 8'h19, 0, 0));
        t1.push_back(mk(86,  0, 16'h0, 4'h0, 4'h0, 4'hE, 8'h19, 0, 0));
        t1.push_back(mk(112, 0, 16'h0, 4'h0, 4'h0, 4'h7, 8'hF9, 0, 0));
        t1.push_back(mk(119, 0, 16'h0, 4'h0, 4'h0, 4'h7, 8'hF9, 0, 0));
        t1.push_back(mk(120, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 1, 1));
        t1.push_back(mk(122, 0, 16'h0, 4'h0, 4'h0, 4'hE, 8'hA1, 0, 1));
        t1.push_back(mk(132, 0, 16'h0, 4'h0, 4'h0, 4'hD, 8'hC6, 0, 1));
        t1.push_back(mk(142, 0, 16'h0, 4'h0, 4'h0, 4'hB, 8'h83, 0, 1));
        t1.push_back(mk(152, 0, 16'h0, 4'h0, 4'h0, 4'h7, 8'h88, 0, 1));
        t1.push_back(mk(159, 1, 16'h9876, 4'b0100, 4'hF, 4'h7, 8'h88, 0, 1));
        t1.push_back(mk(160, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 1, 0));
        t1.push_back(mk(162, 0, 16'h0, 4'h0, 4'h0, 4'hE, 8'hA1, 0, 0));
        t1.push_back(mk(199, 0, 16'h0, 4'h0, 4'h0, 4'h7, 8'h88, 0, 0));
        t1.push_back(mk(200, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 1, 1));
        t1.push_back(mk(201, 1, 16'h4321, 4'b0000, 4'b1010, 4'hF, 8'hFF, 0, 1));
        t1.push_back(mk(202, 0, 16'h0, 4'h0, 4'h0, 4'hE, 8'h82, 0, 0));
        t1.push_back(mk(212, 0, 16'h0, 4'h0, 4'h0, 4'hD, 8'hF8, 0, 0));
        t1.push_back(mk(222, 0, 16'h0, 4'h0, 4'h0, 4'hB, 8'h00, 0, 0));
        t1.push_back(mk(225, 0, 16'h0, 4'h0, 4'h0, 4'hB, 8'h00, 0, 0));

        // After mid-frame reset: dark until a new write, then digit enables
        t2.push_back(mk(0,   0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0, 1));
        t2.push_back(mk(5,   0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0, 1));
        t2.push_back(mk(22,  0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0, 1));
        t2.push_back(mk(40,  0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 1, 1));
        t2.push_back(mk(41,  1, 16'h4321, 4'b0000, 4'b1010, 4'hF, 8'hFF, 0, 1));
        t2.push_back(mk(42,  0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0, 0));
        t2.push_back(mk(79,  0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0, 0));
        t2.push_back(mk(80,  0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 1, 1));
        t2.push_back(mk(82,  0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0, 1));
        t2.push_back(mk(89,  0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0, 1));
        t2.push_back(mk(92,  0, 16'h0, 4'h0, 4'h0, 4'hD, 8'hA4, 0, 1));
        t2.push_back(mk(99,  0, 16'h0, 4'h0, 4'h0, 4'hD, 8'hA4, 0, 1));
        t2.push_back(mk(102, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0, 1));
        t2.push_back(mk(109, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0, 1));
        t2.push_back(mk(112, 0, 16'h0, 4'h0, 4'h0, 4'h7, 8'h99, 0, 1));
        t2.push_back(mk(120, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 1, 1));

        // Reset held: outputs at reset values
        repeat (3) @(posedge clk);
        #1;
        check_outs("in_reset", 4'hF, 8'hFF, 1'b0, 1'b1);
        rst_n = 1'b1;
        cyc   = 0;

        run_table(t1, "t1");

        // Asynchronous reset during digit 2 ON with a write pending
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 4'hF, 8'hFF, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_outs("rst_hold", 4'hF, 8'hFF, 1'b0, 1'b1);
        rst_n = 1'b1;
        cyc   = 0;

        run_table(t2, "t2");

        // Full-frame slot timing with all digits enabled
        step();
        drive_write(16'h1234, 4'b0000, 4'hF);
        while (cyc < 160) step();
        digit_seg[0] = 8'h99;
        digit_seg[1] = 8'hB0;
        digit_seg[2] = 8'hA4;
        digit_seg[3] = 8'hF9;
        for (int c = 160; c < 200; c++) begin
            k = (cyc - 160) % 10;
            s = (cyc - 160) / 10;
            one = 4'b0001 << s;
            exp_sel = (k < 2) ? 4'hF : ~one;
            exp_seg = (k < 2) ? 8'hFF : digit_seg[s];
            chk($sformatf("slot c%0d io_sel", cyc), 32'(io_sel), 32'(exp_sel));
            chk($sformatf("slot c%0d io_seg", cyc), 32'(io_seg), 32'(exp_seg));
            chk($sformatf("slot c%0d frame_start", cyc), 32'(frame_start), 32'(cyc == 160));
            step();
        end
        chk($sformatf("period c%0d frame_start", cyc), 32'(frame_start), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the 4-digit, 8-segment display on the Alchitry IO board. It sits between user logic and the `io_seg`/`io_sel` pins of the top level. It holds a frame-coherent copy of a 16-bit hex value, decimal points and per-digit enables. It scans the digits round-robin with a blanking gap before each digit to suppress ghosting.

## Interface
- `DWELL_CYCLES`, default 100000: clock cycles per digit slot (1 ms at 100 MHz); must be > `BLANK_CYCLES`.
- `BLANK_CYCLES`, default 1000: cycles at the start of each slot with all outputs dark; must be ≥ 1.
- `clk`  in  1  100 MHz system clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `wr_valid`  in  1  new display content offered.
- `wr_ready`  out  1  driver can accept content; transfer occurs when `wr_valid & wr_ready`.
- `wr_value`  in  16  four hex digits; digit 0 = bits [3:0] = rightmost.
- `wr_dp`  in  4  decimal point per digit, 1 = lit.
- `wr_en`  in  4  digit enable, 0 = digit dark for its whole slot.
- `io_seg`  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
- `io_sel`  out  4  active-low digit select, at most one bit low.
- `frame_start`  out  1  one-cycle pulse on the first cycle of digit 0's slot.

## Operation
- Registers:
  - **Shadow:** value, dp and en, written on transfer.
  - **Active:** value, dp and en, used for display.
  - `pending` flag.
  - Digit index 0..3.
  - Phase: BLANK or ON.
  - Phase counter, width `$clog2(DWELL_CYCLES)`.
- **Reset values:**
  - Outputs: `io_seg`=8'hFF, `io_sel`=4'hF, `wr_ready`=1, `frame_start`=0.
  - Internal: active/shadow registers 0 (display fully dark), `pending`=0, index 0, phase BLANK, counter 0.
- **Handshake:**
  - `wr_ready` = ~`pending`.
  - A transfer loads the shadow registers and sets `pending`.
  - Offers made while `wr_ready`=0 are ignored; the shadow registers are unchanged.
- **FSM:**
  - BLANK lasts `BLANK_CYCLES` cycles, then goes to ON.
  - ON lasts `DWELL_CYCLES-BLANK_CYCLES` cycles, then goes to BLANK with index+1; index 3 wraps to 0.
- **Outputs by phase:**
  - BLANK: `io_sel`=4'hF, `io_seg`=8'hFF.
  - ON, digit enabled: `io_sel[idx]`=0, `io_seg` = ~{dp[idx], hex pattern of nibble idx}.
  - ON, digit disabled: `io_sel`=4'hF, `io_seg`=8'hFF. Slot timing is unchanged.
- **Hex patterns** (active-high gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- **Commit (frame boundary):**
  - The boundary is the last ON cycle of digit 3.
  - If `pending` is set, copy shadow to active and clear `pending`.
  - Decisions use the registered `pending`, so a transfer accepted in the boundary cycle commits at the following frame.

## Timing
- All outputs are registered and change only at phase edges. The `wr_ready` change is the exception: it takes effect the cycle after a transfer or commit.
- Slot = `DWELL_CYCLES` cycles; frame = 4×`DWELL_CYCLES` cycles. The scan runs continuously from reset release.
- `frame_start` is high on the first BLANK cycle of digit 0, for one cycle.
  - The first pulse is at cycle 4×`DWELL_CYCLES` after reset release.
  - The slot starting at release has no pulse.
- Commit latency:
  - New content appears at the next digit-0 slot after the next boundary, i.e. within one frame plus one slot.
  - `wr_ready` returns to 1 on the `frame_start` cycle.
- **Reset mid-operation:** outputs go to their reset values immediately (asynchronous), and any pending write is discarded.

## Structure
- Package `seg7_pkg`:
  - 16-entry hex-pattern constant array.
  - Phase enum {BLANK, ON}.
  - Active-low blank constants `SEG_OFF`=8'hFF and `SEL_OFF`=4'hF.
- Sub-module `seg7_hex_decode`: combinational nibble + dp → active-low `io_seg` byte.

## Test plan
All scenarios use `DWELL_CYCLES`=10 and `BLANK_CYCLES`=2.
- **Reset:** hold `rst_n`=0 → `io_seg`=FF, `io_sel`=F, `wr_ready`=1, `frame_start`=0. After release, the first frame is fully dark and `frame_start` pulses at cycle 40, then every 40 cycles.
- **Display content:** write `wr_value`=16'h1234, `wr_dp`=4'b0001, `wr_en`=4'hF at cycle 1. Required from the following frame:
  - Digit 0 ON: `io_sel`=1110, `io_seg`=8'h19.
  - Digit 1 ON: `io_sel`=1101, `io_seg`=8'hB0.
  - Digit 3 ON: `io_sel`=0111, `io_seg`=8'hF9.
- **Slot timing:** each slot has exactly 2 cycles of `io_sel`=F/`io_seg`=FF followed by exactly 8 cycles of one-hot-low `io_sel`. Select is never low during BLANK.
- **Handshake:**
  - A second write while pending → `wr_ready`=0, the offer is ignored, and old content stays displayed until the boundary.
  - A write accepted exactly on the boundary cycle commits one frame later.
- **Digit enable:** `wr_en`=4'b1010 → digits 0 and 2 keep `io_sel`=F for all 10 cycles of their slots; digits 1 and 3 display normally; frame period stays 40.
- **Reset mid-frame:** assert `rst_n`=0 during digit 2 ON → outputs go to FF/F within the same cycle. After release, the display is dark until a new write commits.
